// File: rtl/bus_arbiter_split_pkg.sv
// Shared types and sizing helpers for the split-capable bus arbiter.
package bus_arbiter_split_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    OWNED       = 3'd1,
    SPLIT_FREE  = 3'd2,
    SPLIT_OWNED = 3'd3,
    RESUME      = 3'd4
  } arb_state_t;

  function automatic int owner_w(input int num_m);
    return (num_m <= 2) ? 1 : $clog2(num_m);
  endfunction

endpackage

// File: rtl/bus_arbiter_split_rr_pick.sv
// Combinational round-robin selector: first set mask bit at or above the pointer, wrapping.
module bus_arbiter_split_rr_pick
  import bus_arbiter_split_pkg::*;
#(
  parameter  int NUM_M   = 2,
  localparam int OWNER_W = owner_w(NUM_M)
) (
  input  logic [NUM_M-1:0]   i_mask,
  input  logic [OWNER_W-1:0] i_ptr,
  output logic [OWNER_W-1:0] o_idx,
  output logic               o_found
);

  logic [NUM_M-1:0]   w_rot;
  logic [OWNER_W-1:0] w_ofs;
  logic [OWNER_W:0]   w_sum;

  assign w_rot = NUM_M'({i_mask, i_mask} >> i_ptr);

  // Descending scan so the lowest set bit of the rotated mask is what remains.
  always_comb begin
    w_ofs   = {OWNER_W{1'b0}};
    o_found = 1'b0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      w_ofs   = w_rot[k] ? OWNER_W'(k) : w_ofs;
      o_found = o_found | w_rot[k];
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_ofs};
  assign o_idx = (w_sum >= (OWNER_W+1)'(NUM_M)) ? OWNER_W'(w_sum - (OWNER_W+1)'(NUM_M))
                                                 : OWNER_W'(w_sum);

endmodule

// File: rtl/bus_arbiter_split.sv
// Round-robin bus arbiter that parks a split master, lends the bus out,
// and re-grants the parked master with a one-cycle resume pulse.
module bus_arbiter_split
  import bus_arbiter_split_pkg::*;
#(
  parameter  int NUM_M         = 2,
  parameter  int SPLIT_TIMEOUT = 255,
  localparam int OWNER_W       = owner_w(NUM_M)
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [NUM_M-1:0]   M_BREQ,
  output logic [NUM_M-1:0]   M_BGRANT,
  output logic [OWNER_W-1:0] BUS_OWNER,
  output logic               BUS_VALID,
  input  logic               B_SBSY,
  output logic               B_SPLIT,
  output logic               B_SPL_RESUME,
  output logic               SPLIT_ERR
);

  localparam int                 CNT_W    = $clog2(SPLIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(SPLIT_TIMEOUT);
  localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_M - 1);
  localparam logic [NUM_M-1:0]   ONE_M    = {{(NUM_M-1){1'b0}}, 1'b1};

  arb_state_t         r_state;
  logic [OWNER_W-1:0] r_rr_ptr;
  logic [OWNER_W-1:0] r_split_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_M-1:0]   r_grant;
  logic [OWNER_W-1:0] r_owner;
  logic               r_valid;
  logic               r_split;
  logic               r_resume;
  logic               r_err;

  logic               w_split_pend;
  logic [NUM_M-1:0]   w_split_bit;
  logic [NUM_M-1:0]   w_owner_bit;
  logic [NUM_M-1:0]   w_elig;
  logic               w_owner_req;
  logic               w_split_req;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_expire;
  logic               w_abort;
  logic [OWNER_W-1:0] w_win;
  logic               w_found;
  logic [NUM_M-1:0]   w_win_bit;
  logic [OWNER_W-1:0] w_ptr_nxt;

  assign w_split_pend = (r_state == SPLIT_FREE) || (r_state == SPLIT_OWNED);
  assign w_split_bit  = ONE_M << r_split_idx;
  assign w_owner_bit  = ONE_M << r_owner;
  assign w_elig       = M_BREQ & ~(w_split_pend ? w_split_bit : {NUM_M{1'b0}});
  assign w_owner_req  = |(M_BREQ & w_owner_bit);
  assign w_split_req  = |(M_BREQ & w_split_bit);
  // The counter reaching the limit on this edge ends the split on this same edge.
  assign w_cnt_nxt    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_expire     = (w_cnt_nxt == CNT_MAX);
  assign w_abort      = w_expire || !w_split_req;
  assign w_win_bit    = ONE_M << w_win;
  assign w_ptr_nxt    = (w_win == LAST_IDX) ? {OWNER_W{1'b0}} : w_win + 1'b1;

  bus_arbiter_split_rr_pick #(.NUM_M(NUM_M)) u_rr_pick (
    .i_mask  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  // Arbitration FSM, split bookkeeping, timeout counter and all bus outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= IDLE;
      r_rr_ptr    <= {OWNER_W{1'b0}};
      r_split_idx <= {OWNER_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_grant     <= {NUM_M{1'b0}};
      r_owner     <= {OWNER_W{1'b0}};
      r_valid     <= 1'b0;
      r_split     <= 1'b0;
      r_resume    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_resume <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant  <= w_win_bit;
            r_owner  <= w_win;
            r_valid  <= 1'b1;
            r_rr_ptr <= w_ptr_nxt;
            r_state  <= OWNED;
          end
        end
        OWNED: begin
          if (!w_owner_req) begin
            r_grant <= {NUM_M{1'b0}};
            r_valid <= 1'b0;
            r_state <= IDLE;
          end else if (B_SBSY) begin
            r_grant     <= {NUM_M{1'b0}};
            r_valid     <= 1'b0;
            r_split     <= 1'b1;
            r_split_idx <= r_owner;
            r_cnt       <= {CNT_W{1'b0}};
            r_state     <= SPLIT_FREE;
          end
        end
        SPLIT_FREE: begin
          r_cnt <= w_cnt_nxt;
          // A vanished split master cancels even a ready slave; otherwise resume beats timeout.
          if (!w_split_req || (B_SBSY && w_expire)) begin
            r_split <= 1'b0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (!B_SBSY) begin
            r_grant  <= w_split_bit;
            r_owner  <= r_split_idx;
            r_valid  <= 1'b1;
            r_resume <= 1'b1;
            r_state  <= RESUME;
          end else if (w_found) begin
            r_grant  <= w_win_bit;
            r_owner  <= w_win;
            r_valid  <= 1'b1;
            r_rr_ptr <= w_ptr_nxt;
            r_state  <= SPLIT_OWNED;
          end
        end
        SPLIT_OWNED: begin
          r_cnt <= w_cnt_nxt;
          if (w_abort) begin
            r_split <= 1'b0;
            r_err   <= 1'b1;
            if (w_owner_req) begin
              r_state <= OWNED;
            end else begin
              r_grant <= {NUM_M{1'b0}};
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end else if (!w_owner_req) begin
            r_grant <= {NUM_M{1'b0}};
            r_valid <= 1'b0;
            r_state <= SPLIT_FREE;
          end
        end
        RESUME: begin
          r_split <= 1'b0;
          r_state <= OWNED;
        end
        default: begin
          r_grant <= {NUM_M{1'b0}};
          r_valid <= 1'b0;
          r_split <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign M_BGRANT     = r_grant;
  assign BUS_OWNER    = r_owner;
  assign BUS_VALID    = r_valid;
  assign B_SPLIT      = r_split;
  assign B_SPL_RESUME = r_resume;
  assign SPLIT_ERR    = r_err;

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Directed bench for bus_arbiter_split; status word = {grant[1:0], owner, valid, split, resume, err}.
module tb_bus_arbiter_split;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic [1:0] breq, t_breq;
  logic       sbsy, t_sbsy;
  logic [1:0] grant, t_grant;
  logic       owner, t_owner, valid, t_valid;
  logic       split, t_split, resume, t_resume, err, t_err;
  logic [6:0] st, t_st;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  always #5 CLK = ~CLK;

  assign st   = {grant, owner, valid, split, resume, err};
  assign t_st = {t_grant, t_owner, t_valid, t_split, t_resume, t_err};

  bus_arbiter_split #(.NUM_M(2), .SPLIT_TIMEOUT(255)) dut (
    .CLK(CLK), .RSTN(RSTN), .M_BREQ(breq), .M_BGRANT(grant), .BUS_OWNER(owner),
    .BUS_VALID(valid), .B_SBSY(sbsy), .B_SPLIT(split), .B_SPL_RESUME(resume), .SPLIT_ERR(err)
  );

  bus_arbiter_split #(.NUM_M(2), .SPLIT_TIMEOUT(8)) dut_to (
    .CLK(CLK), .RSTN(RSTN), .M_BREQ(t_breq), .M_BGRANT(t_grant), .BUS_OWNER(t_owner),
    .BUS_VALID(t_valid), .B_SBSY(t_sbsy), .B_SPLIT(t_split), .B_SPL_RESUME(t_resume), .SPLIT_ERR(t_err)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTN = 1'b0; breq = 2'b00; t_breq = 2'b00; sbsy = 1'b0; t_sbsy = 1'b0;
    tick(); tick();
    vec_cnt++;
    if (st !== 7'b0000000) begin err_cnt++; $display("FAIL reset_main got %b exp %b", st, 7'b0000000); end
    vec_cnt++;
    if (t_st !== 7'b0000000) begin err_cnt++; $display("FAIL reset_to got %b exp %b", t_st, 7'b0000000); end
    RSTN = 1'b1;
    tick();
    vec_cnt++;
    if (st !== 7'b0000000) begin err_cnt++; $display("FAIL reset_idle got %b exp %b", st, 7'b0000000); end
  endtask

  task automatic test_round_robin();
    logic [1:0] req_v [12] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11,
                               2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00};
    logic [6:0] exp_st [12] = '{7'b0101000, 7'b0101000, 7'b0101000, 7'b0101000,
                                7'b0000000, 7'b1011000, 7'b1011000, 7'b1011000,
                                7'b1011000, 7'b0010000, 7'b0101000, 7'b0000000};
    for (int i = 0; i < 12; i++) begin
      breq = req_v[i]; sbsy = 1'b0;
      tick();
      vec_cnt++;
      if (st !== exp_st[i]) begin err_cnt++; $display("FAIL rr[%0d] got %b exp %b", i, st, exp_st[i]); end
    end
  endtask

  task automatic test_split_lend_resume();
    logic [2:0] stim [10] = '{3'b010, 3'b010, 3'b111, 3'b111, 3'b110,
                              3'b110, 3'b010, 3'b010, 3'b010, 3'b000};
    logic [6:0] exp_st [10] = '{7'b0101000, 7'b0101000, 7'b0000100, 7'b1011100, 7'b1011100,
                                7'b1011100, 7'b0010100, 7'b0101110, 7'b0101000, 7'b0000000};
    for (int i = 0; i < 10; i++) begin
      {breq, sbsy} = stim[i];
      tick();
      vec_cnt++;
      if (st !== exp_st[i]) begin err_cnt++; $display("FAIL split_lend[%0d] got %b exp %b", i, st, exp_st[i]); end
    end
  endtask

  task automatic test_resume_free();
    logic [2:0] stim [15];
    logic [6:0] exp_st [15];
    stim[0] = 3'b100; exp_st[0] = 7'b1011000;
    for (int i = 1; i < 12; i++) begin stim[i] = 3'b101; exp_st[i] = 7'b0010100; end
    stim[12] = 3'b100; exp_st[12] = 7'b1011110;
    stim[13] = 3'b100; exp_st[13] = 7'b1011000;
    stim[14] = 3'b000; exp_st[14] = 7'b0010000;
    for (int i = 0; i < 15; i++) begin
      {breq, sbsy} = stim[i];
      tick();
      vec_cnt++;
      if (st !== exp_st[i]) begin err_cnt++; $display("FAIL resume_free[%0d] got %b exp %b", i, st, exp_st[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [2:0] stim [12];
    logic [6:0] exp_st [12];
    stim[0] = 3'b010; exp_st[0] = 7'b0101000;
    for (int i = 1; i < 9; i++) begin stim[i] = 3'b011; exp_st[i] = 7'b0000100; end
    stim[9]  = 3'b011; exp_st[9]  = 7'b0000001;
    stim[10] = 3'b011; exp_st[10] = 7'b0101000;
    stim[11] = 3'b000; exp_st[11] = 7'b0000000;
    for (int i = 0; i < 12; i++) begin
      {t_breq, t_sbsy} = stim[i];
      tick();
      vec_cnt++;
      if (t_st !== exp_st[i]) begin err_cnt++; $display("FAIL timeout[%0d] got %b exp %b", i, t_st, exp_st[i]); end
    end
  endtask

  task automatic test_cancel();
    logic [2:0] stim [5] = '{3'b010, 3'b011, 3'b011, 3'b001, 3'b000};
    logic [6:0] exp_st [5] = '{7'b0101000, 7'b0000100, 7'b0000100, 7'b0000001, 7'b0000000};
    for (int i = 0; i < 5; i++) begin
      {breq, sbsy} = stim[i];
      tick();
      vec_cnt++;
      if (st !== exp_st[i]) begin err_cnt++; $display("FAIL cancel[%0d] got %b exp %b", i, st, exp_st[i]); end
    end
  endtask

  task automatic test_reset_in_resume();
    logic [2:0] stim [3] = '{3'b010, 3'b011, 3'b010};
    logic [6:0] exp_st [3] = '{7'b0101000, 7'b0000100, 7'b0101110};
    for (int i = 0; i < 3; i++) begin
      {breq, sbsy} = stim[i];
      tick();
      vec_cnt++;
      if (st !== exp_st[i]) begin err_cnt++; $display("FAIL rst_seq[%0d] got %b exp %b", i, st, exp_st[i]); end
    end
    breq = 2'b11; sbsy = 1'b0;
    RSTN = 1'b0;
    #1;
    vec_cnt++;
    if (st !== 7'b0000000) begin err_cnt++; $display("FAIL rst_async got %b exp %b", st, 7'b0000000); end
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    tick();
    vec_cnt++;
    if (st !== 7'b0101000) begin err_cnt++; $display("FAIL rst_rr_ptr got %b exp %b", st, 7'b0101000); end
    breq = 2'b00;
    tick();
    vec_cnt++;
    if (st !== 7'b0000000) begin err_cnt++; $display("FAIL rst_release got %b exp %b", st, 7'b0000000); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_split_lend_resume();
    test_resume_free();
    test_timeout();
    test_cancel();
    test_reset_in_resume();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_split.md
Name: bus_arbiter_split

Overview:
- Central arbiter for the shared serial bus. It grants bus ownership among NUM_M masters with round-robin priority.
- Handles split transactions from the 4K split-capable slave:
  - parks the split master while the slave is busy (B_SBSY);
  - lends the bus to other masters meanwhile;
  - re-grants the parked master with a one-cycle B_SPL_RESUME pulse when the slave is ready.
- Drives the bus mux select (BUS_OWNER) and the global B_SPLIT / B_SPL_RESUME lines seen by all slaves.

Parameters:
- NUM_M, 2, number of masters (2..8).
- SPLIT_TIMEOUT, 255, maximum cycles a split may stay pending before abort.

Ports:
- CLK  input  1  clock, rising edge.
- RSTN  input  1  reset, asynchronous, active-low.
- M_BREQ  input  NUM_M  per-master bus request, level; held for the whole tenure, including while split.
- M_BGRANT  output  NUM_M  one-hot-or-zero grant.
- BUS_OWNER  output  OWNER_W  index of the granted master (mux select); OWNER_W = max(1, $clog2(NUM_M)).
- BUS_VALID  output  1  high when any grant is active.
- B_SBSY  input  1  slave busy / split request from the addressed slave.
- B_SPLIT  output  1  split in progress; broadcast to slaves.
- B_SPL_RESUME  output  1  one-cycle resume pulse; always coincident with B_SPLIT=1.
- SPLIT_ERR  output  1  one-cycle pulse on split timeout or cancel.

Behaviour:
- All outputs are registered.
- Reset values: M_BGRANT=0, BUS_OWNER=0, BUS_VALID=0, B_SPLIT=0, B_SPL_RESUME=0, SPLIT_ERR=0. Internal state: FSM=IDLE, rr_ptr=0, split_idx=0, timeout count=0.
- FSM states: IDLE, OWNED, SPLIT_FREE, SPLIT_OWNED, RESUME.
- Arbitration: the eligible set is M_BREQ with split_idx masked while a split is pending. The winner is the first eligible index at or above rr_ptr, wrapping modulo NUM_M. rr_ptr becomes winner+1 (mod NUM_M) at each grant.
- IDLE:
  - An eligible request sampled at cycle N sets M_BGRANT/BUS_OWNER/BUS_VALID at N+1 → OWNED.
- OWNED:
  - Owner's M_BREQ sampled low at N drops its grant at N+1 → IDLE. The next grant is issued no earlier than N+2 (one-cycle turnaround).
  - B_SBSY sampled high at N (owner still requesting): at N+1 B_SPLIT=1, split_idx=owner, grant=0, timeout counter cleared → SPLIT_FREE.
- SPLIT_FREE (split pending, bus free):
  - Resume has priority over new requests.
  - B_SBSY sampled low at N: at N+1 B_SPL_RESUME=1, M_BGRANT[split_idx]=1 → RESUME.
  - Otherwise, if another master is eligible, grant it at N+1 → SPLIT_OWNED.
- SPLIT_OWNED (split pending, another master on the bus):
  - Lender's M_BREQ low at N drops its grant at N+1 → SPLIT_FREE.
  - B_SBSY is ignored as a new split in this state; only one split is outstanding at a time.
  - Resume waits for the lender's release, even if B_SBSY has already fallen.
- RESUME:
  - Lasts exactly one cycle with B_SPLIT=1 and B_SPL_RESUME=1.
  - Next cycle B_SPLIT=0, B_SPL_RESUME=0 → OWNED, owner=split_idx.
  - rr_ptr is not changed by a resume.
- Timeout:
  - The counter increments every cycle in SPLIT_FREE / SPLIT_OWNED and saturates.
  - When it reaches SPLIT_TIMEOUT: next cycle B_SPLIT=0, SPLIT_ERR=1 for one cycle, split cleared.
  - Target state after timeout: SPLIT_OWNED → OWNED (lender keeps the bus); SPLIT_FREE → IDLE.
- Cancel: if M_BREQ[split_idx] is sampled low while the split is pending, apply the same action as timeout (SPLIT_ERR pulse, B_SPLIT cleared).
- Simultaneous events:
  - Timeout and resume condition in the same cycle: resume wins.
  - Owner release and B_SBSY high in the same cycle: release wins, no split.
- Reset mid-transaction: all grants and split lines drop immediately (asynchronous).

Decomposition:
- Shared package: arb_state_t enum, and function owner_w(NUM_M) for OWNER_W.
- One sub-module, rr_pick: combinational round-robin selector. Inputs: eligible mask and rr_ptr. Outputs: winner index and a found flag.
- FSM, split bookkeeping and timeout counter stay in the top module.

Test Plan:
- Round-robin: M_BREQ=2'b11 held, each master releases after 4 cycles of tenure → grants alternate 01,10,01 with one idle cycle between tenures; BUS_OWNER tracks the grant.
- Split/lend/resume:
  - M0 owns; B_SBSY=1 at N → B_SPLIT=1, M_BGRANT=00 at N+1; M1 granted at N+2.
  - B_SBSY falls while M1 owns → no resume until M1 releases.
  - Then B_SPL_RESUME pulses 1 cycle with M_BGRANT=01; B_SPLIT=0 the next cycle.
- Resume with bus free: split M1, no other requests, B_SBSY low after 10 cycles → B_SPL_RESUME at the cycle after sampling, grant 10, BUS_OWNER=1.
- Timeout: SPLIT_TIMEOUT=8, B_SBSY held high → after 8 pending cycles SPLIT_ERR pulses once, B_SPLIT=0, split master not regranted until re-arbitrated.
- Cancel and reset: split master drops M_BREQ mid-split → SPLIT_ERR pulse, B_SPLIT=0. Separately, RSTN asserted during RESUME → all outputs 0 asynchronously; after release, rr_ptr=0 so M0 wins first.
